// File: rtl/pipeline_fifo_if.sv
// rtl/pipeline_fifo_if.sv - enqueue/dequeue handshake and status bundle for pipeline_fifo
interface pipeline_fifo_if #(
  parameter int N     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          we;
  logic [N-1:0]  wdata;
  logic          re;
  logic [N-1:0]  rdata;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  // Producer/consumer side drives requests and observes status.
  modport master (
    output we, wdata, re,
    input  rdata, full, empty, count
  );

  // FIFO side consumes requests and drives status.
  modport slave (
    input  we, wdata, re,
    output rdata, full, empty, count
  );
endinterface

// File: rtl/pipeline_fifo.sv
// rtl/pipeline_fifo.sv - registered-status FIFO where dequeue logically precedes enqueue
module pipeline_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_fifo_if.slave  fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          deq_fire;
  logic          enq_fire;

  // A full FIFO still takes a write when a read frees the head slot this cycle.
  assign deq_fire = fifo.re & ~empty_q;
  assign enq_fire = fifo.we & (~full_q | deq_fire);

  // Occupancy moves only when exactly one side fires.
  always_comb begin
    count_nxt = count_q;
    if (enq_fire && !deq_fire) begin
      count_nxt = count_q + CW'(1);
    end else if (deq_fire && !enq_fire) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // Pointers, count and flags; flags are precomputed so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage array is deliberately left out of reset; stale contents are hidden by empty.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      mem[wr_ptr] <= fifo.wdata;
    end
  end

  // Head entry is read from the array at the registered read pointer, never from wdata.
  assign fifo.rdata = mem[rd_ptr];
  assign fifo.count = count_q;
  assign fifo.empty = empty_q;
  assign fifo.full  = full_q;
endmodule

// File: tb/tb_pipeline_fifo.sv
// tb/tb_pipeline_fifo.sv - self-checking bench for pipeline_fifo against a queue model
module tb_pipeline_fifo;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  pipeline_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

  pipeline_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  logic [N-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":count"}, 64'(bus.count), 64'(q.size()));
    chk({tag, ":empty"}, 64'(bus.empty), 64'(q.size() == 0));
    chk({tag, ":full"},  64'(bus.full),  64'(q.size() == DEPTH));
    if (q.size() > 0) begin
      chk({tag, ":rdata"}, 64'(bus.rdata), 64'(q[0]));
    end
  endtask

  // Apply one cycle of stimulus; outputs must not react before the edge, then must match the model.
  task automatic step(input logic w, input logic [N-1:0] d, input logic r, input logic rs,
                      input string tag);
    bit deq;
    bit enq;
    bus.we    = w;
    bus.wdata = d;
    bus.re    = r;
    rst       = rs;
    #1;
    check_outputs({tag, "/pre"});
    @(posedge clk);
    if (rs) begin
      q.delete();
    end else begin
      deq = r && (q.size() > 0);
      enq = w && ((q.size() < DEPTH) || deq);
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(d);
    end
    #1;
    check_outputs({tag, "/post"});
  endtask

  initial begin
    bus.we    = 1'b0;
    bus.wdata = '0;
    bus.re    = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;

    // Reset and single entry
    step(1'b0, '0, 1'b0, 1'b1, "rst1");
    step(1'b0, '0, 1'b0, 1'b1, "rst2");
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full",  64'(bus.full),  64'd0);
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, "single");
    chk("single_rdata", 64'(bus.rdata), 64'hA5A5_A5A5);
    chk("single_count", 64'(bus.count), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0, "single_drain");

    // Fill, drop on full, ordered drain
    for (int i = 1; i <= 4; i++) step(1'b1, N'(i), 1'b0, 1'b0, "fill");
    chk("fill_full",  64'(bus.full),  64'd1);
    chk("fill_count", 64'(bus.count), 64'd4);
    step(1'b1, 32'd99, 1'b0, 1'b0, "drop");
    chk("drop_head", 64'(bus.rdata), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
    chk("drain_empty", 64'(bus.empty), 64'd1);

    // Enqueue while full together with dequeue
    for (int i = 1; i <= 4; i++) step(1'b1, N'(i), 1'b0, 1'b0, "refill");
    step(1'b1, 32'd5, 1'b1, 1'b0, "full_both");
    chk("full_both_full",  64'(bus.full),  64'd1);
    chk("full_both_count", 64'(bus.count), 64'd4);
    chk("full_both_head",  64'(bus.rdata), 64'd2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, "drain2");

    // Enqueue while empty with a read request
    step(1'b1, 32'd7, 1'b1, 1'b0, "empty_both");
    chk("empty_both_rdata", 64'(bus.rdata), 64'd7);
    chk("empty_both_count", 64'(bus.count), 64'd1);

    // Steady count of two across pointer wrap
    step(1'b1, 32'd100, 1'b0, 1'b0, "wrap_pre");
    for (int i = 0; i < 3 * DEPTH + 1; i++) step(1'b1, N'(200 + i), 1'b1, 1'b0, "wrap");
    chk("wrap_count", 64'(bus.count), 64'd2);
    step(1'b0, '0, 1'b1, 1'b0, "wrap_drain");
    step(1'b0, '0, 1'b1, 1'b0, "wrap_drain");

    // Reset mid-operation overriding we and re
    for (int i = 0; i < 3; i++) step(1'b1, N'(300 + i), 1'b0, 1'b0, "mid_fill");
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, "mid_rst");
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_empty", 64'(bus.empty), 64'd1);
    chk("mid_rst_full",  64'(bus.full),  64'd0);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, "post_rst");
    chk("post_rst_head", 64'(bus.rdata), 64'h1234_5678);
    step(1'b0, '0, 1'b1, 1'b0, "post_rst_drain");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0), "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
